// File: rtl/calc_core_gen_if.sv
// Handshake and result bundle between a client and the calc_core_gen arithmetic core.
`timescale 1ns/1ps
interface calc_core_gen_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             op_valid;
    logic [2:0]       op_code;
    logic             op_ready;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             overflow;
    logic             div_zero;
    logic [4:0]       state_o;

    modport master (
        output clear, in_valid, in_data, op_valid, op_code,
        input  in_ready, op_ready, result, result_valid, overflow, div_zero, state_o
    );

    modport slave (
        input  clear, in_valid, in_data, op_valid, op_code,
        output in_ready, op_ready, result, result_valid, overflow, div_zero, state_o
    );
endinterface

// File: rtl/calc_core_gen.sv
// Chaining accumulator ALU: operand A, opcode, operand B, then a registered result that
// becomes the next A. Division uses a restoring divider, one quotient bit per cycle.
`timescale 1ns/1ps
module calc_core_gen #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            reset,
    calc_core_gen_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        OPWAIT = 5'b00010,
        BWAIT  = 5'b00100,
        EXEC   = 5'b01000,
        DONE   = 5'b10000
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, result_reg, quo_reg, rem_reg;
    logic [2:0]       op_reg;
    logic             overflow_reg, div_zero_reg;
    logic [CW-1:0]    step_cnt;

    logic             in_fire, op_fire, div_iter, exec_last;
    logic [WIDTH:0]   rem_shift, sum;
    logic [WIDTH-1:0] rem_next, quo_next, alu_result;
    logic [2*WIDTH-1:0] product;
    logic             alu_overflow, alu_div_zero;

    assign bus.in_ready     = (state == IDLE) || (state == OPWAIT) || (state == BWAIT);
    assign bus.op_ready     = (state == OPWAIT);
    assign bus.result       = result_reg;
    assign bus.result_valid = (state == DONE);
    assign bus.overflow     = overflow_reg;
    assign bus.div_zero     = div_zero_reg;
    assign bus.state_o      = state;

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign op_fire   = bus.op_valid && bus.op_ready;
    assign div_iter  = (op_reg == OP_DIV) && (b_reg != '0);
    assign exec_last = !div_iter || (step_cnt == LAST_STEP);

    assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign sum       = {1'b0, a_reg} + {1'b0, b_reg};
    assign product   = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};

    // One restoring-division step: the partial remainder is always below B, so WIDTH bits hold it.
    always_comb begin
        rem_next = rem_shift[WIDTH-1:0];
        quo_next = {quo_reg[WIDTH-2:0], 1'b0};
        if (rem_shift >= {1'b0, b_reg}) begin
            rem_next = rem_shift[WIDTH-1:0] - b_reg;
            quo_next = {quo_reg[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        alu_result   = b_reg;
        alu_overflow = 1'b0;
        alu_div_zero = 1'b0;
        case (op_reg)
            OP_ADD: begin
                alu_result   = sum[WIDTH-1:0];
                alu_overflow = sum[WIDTH];
            end
            OP_SUB: begin
                alu_result   = a_reg - b_reg;
                alu_overflow = (a_reg < b_reg);
            end
            OP_AND: alu_result = a_reg & b_reg;
            OP_OR:  alu_result = a_reg | b_reg;
            OP_XOR: alu_result = a_reg ^ b_reg;
            OP_MUL: begin
                alu_result   = product[WIDTH-1:0];
                alu_overflow = |product[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (b_reg == '0) begin
                    alu_result   = '1;
                    alu_div_zero = 1'b1;
                end else begin
                    alu_result = quo_next;
                end
            end
            default: alu_result = b_reg;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (in_fire) state_next = OPWAIT;
            OPWAIT: begin
                if (op_fire && in_fire) state_next = EXEC;
                else if (op_fire)       state_next = BWAIT;
            end
            BWAIT:  if (in_fire) state_next = EXEC;
            EXEC:   if (exec_last) state_next = DONE;
            DONE:   state_next = OPWAIT;
            default: state_next = IDLE;
        endcase
        if (bus.clear) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, divider iteration and result commit; clear wipes everything like reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            div_zero_reg <= 1'b0;
            quo_reg      <= '0;
            rem_reg      <= '0;
            step_cnt     <= '0;
        end else if (bus.clear) begin
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            div_zero_reg <= 1'b0;
            quo_reg      <= '0;
            rem_reg      <= '0;
            step_cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (in_fire) a_reg <= bus.in_data;
                OPWAIT: begin
                    if (op_fire) op_reg <= bus.op_code;
                    if (in_fire && op_fire) begin
                        b_reg    <= bus.in_data;
                        quo_reg  <= a_reg;
                        rem_reg  <= '0;
                        step_cnt <= '0;
                    end else if (in_fire) begin
                        a_reg <= bus.in_data;
                    end
                end
                BWAIT: begin
                    if (in_fire) begin
                        b_reg    <= bus.in_data;
                        quo_reg  <= a_reg;
                        rem_reg  <= '0;
                        step_cnt <= '0;
                    end
                end
                EXEC: begin
                    if (div_iter) begin
                        quo_reg  <= quo_next;
                        rem_reg  <= rem_next;
                        step_cnt <= step_cnt + 1'b1;
                    end
                    if (exec_last) begin
                        result_reg   <= alu_result;
                        overflow_reg <= alu_overflow;
                        div_zero_reg <= alu_div_zero;
                    end
                end
                DONE: a_reg <= result_reg;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_core_gen.sv
// Directed-vector bench for calc_core_gen at WIDTH = 8 with hand-computed expectations.
`timescale 1ns/1ps
module tb_calc_core_gen;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    int   test_count = 0;
    int   fail_count = 0;

    calc_core_gen_if #(.WIDTH(WIDTH)) bus ();

    calc_core_gen #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        test_count++;
        if (got !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic in_v, input logic [WIDTH-1:0] data,
                                 input logic op_v, input logic [2:0] code);
        bus.in_valid = in_v;
        bus.in_data  = data;
        bus.op_valid = op_v;
        bus.op_code  = code;
        tick();
        bus.in_valid = 1'b0;
        bus.op_valid = 1'b0;
    endtask

    task automatic send_operand(input logic [WIDTH-1:0] data);
        applyStimulus(1'b1, data, 1'b0, 3'b000);
    endtask

    task automatic send_op(input logic [2:0] code);
        applyStimulus(1'b0, '0, 1'b1, code);
    endtask

    // Latency counts clock edges from the B-accepting edge to the edge that samples result_valid.
    task automatic wait_and_check(input string tag, input int exp_lat, input logic [WIDTH-1:0] exp_res,
                                  input logic exp_ovf, input logic exp_dz);
        int n = 0;
        while (!bus.result_valid && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, "_latency"}, n + 1, exp_lat);
        checkOutput({tag, "_result"}, bus.result, exp_res);
        checkOutput({tag, "_overflow"}, bus.overflow, exp_ovf);
        checkOutput({tag, "_div_zero"}, bus.div_zero, exp_dz);
        tick();
        checkOutput({tag, "_pulse_end"}, bus.result_valid, 1'b0);
        checkOutput({tag, "_state_after"}, bus.state_o, 5'b00010);
        checkOutput({tag, "_result_held"}, bus.result, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [2:0] code, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_res, input logic exp_ovf, input logic exp_dz,
                          input int exp_lat);
        send_op(code);
        send_operand(b);
        wait_and_check(tag, exp_lat, exp_res, exp_ovf, exp_dz);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_state"}, bus.state_o, 5'b00001);
        checkOutput({tag, "_result"}, bus.result, 0);
        checkOutput({tag, "_result_valid"}, bus.result_valid, 0);
        checkOutput({tag, "_overflow"}, bus.overflow, 0);
        checkOutput({tag, "_div_zero"}, bus.div_zero, 0);
    endtask

    initial begin
        int seen;
        reset        = 1'b1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'b000;
        #2;
        check_reset_values("reset");
        checkOutput("reset_in_ready", bus.in_ready, 1);
        checkOutput("reset_op_ready", bus.op_ready, 0);
        #10 reset = 1'b0;

        send_operand(8'd25);
        checkOutput("idle_to_opwait", bus.state_o, 5'b00010);
        checkOutput("opwait_op_ready", bus.op_ready, 1);
        send_op(3'b000);
        checkOutput("opwait_to_bwait", bus.state_o, 5'b00100);
        checkOutput("bwait_op_ready", bus.op_ready, 0);
        checkOutput("bwait_in_ready", bus.in_ready, 1);
        send_operand(8'd17);
        checkOutput("bwait_to_exec", bus.state_o, 5'b01000);
        checkOutput("exec_in_ready", bus.in_ready, 0);
        wait_and_check("add", 2, 8'd42, 1'b0, 1'b0);

        run_op("sub", 3'b001, 8'd50, 8'd248, 1'b1, 1'b0, 2);
        run_op("mul", 3'b101, 8'd13, 8'd152, 1'b1, 1'b0, 2);

        send_operand(8'd100);
        checkOutput("restart_state", bus.state_o, 5'b00010);
        run_op("div", 3'b110, 8'd7, 8'd14, 1'b0, 1'b0, 9);
        send_operand(8'd9);
        run_op("div0", 3'b110, 8'd0, 8'd255, 1'b0, 1'b1, 2);

        send_operand(8'd5);
        applyStimulus(1'b1, 8'd3, 1'b1, 3'b000);
        checkOutput("same_edge_state", bus.state_o, 5'b01000);
        wait_and_check("same_edge", 2, 8'd8, 1'b0, 1'b0);
        send_operand(8'd60);
        run_op("or", 3'b011, 8'd3, 8'd63, 1'b0, 1'b0, 2);

        send_operand(8'd11);
        send_op(3'b000);
        applyStimulus(1'b0, '0, 1'b1, 3'b100);
        checkOutput("bwait_ignores_op", bus.state_o, 5'b00100);
        bus.clear = 1'b1;
        applyStimulus(1'b1, 8'd99, 1'b0, 3'b000);
        bus.clear = 1'b0;
        check_reset_values("clear");

        send_operand(8'd1);
        run_op("passb", 3'b111, 8'd6, 8'd6, 1'b0, 1'b0, 2);
        run_op("xor", 3'b100, 8'd10, 8'd12, 1'b0, 1'b0, 2);
        run_op("and", 3'b010, 8'd10, 8'd8, 1'b0, 1'b0, 2);

        send_operand(8'd100);
        send_op(3'b110);
        send_operand(8'd7);
        tick();
        tick();
        checkOutput("div_third_cycle", bus.state_o, 5'b01000);
        #2 reset = 1'b1;
        #1;
        check_reset_values("mid_div_reset");
        #10 reset = 1'b0;
        seen = 0;
        repeat (12) begin
            tick();
            if (bus.result_valid) seen++;
        end
        checkOutput("no_valid_after_reset", seen, 0);
        checkOutput("idle_after_reset", bus.state_o, 5'b00001);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit");
    end
endmodule

// File: doc/calc_core_gen.md
CALC_CORE_GEN -- requirements
Module: calc_core_gen

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width (WIDTH >= 4).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: clear  input  1  synchronous abort; returns core to IDLE.
REQ-005 Port: in_valid  input  1  operand offered.
REQ-006 Port: in_data  input  WIDTH  unsigned operand.
REQ-007 Port: in_ready  output  1  operand accepted when in_valid && in_ready at clock edge.
REQ-008 Port: op_valid  input  1  opcode offered.
REQ-009 Port: op_code  input  3  operation select.
REQ-010 Port: op_ready  output  1  opcode accepted when op_valid && op_ready at clock edge.
REQ-011 Port: result  output  WIDTH  registered result / accumulator.
REQ-012 Port: result_valid  output  1  one-cycle pulse marking a new result.
REQ-013 Port: overflow  output  1  sticky-per-result carry/borrow/product overflow flag.
REQ-014 Port: div_zero  output  1  sticky-per-result divide-by-zero flag.
REQ-015 Port: state_o  output  5  one-hot state {DONE,EXEC,BWAIT,OPWAIT,IDLE} (bit4..bit0).

Function
REQ-016 FSM states: IDLE, OPWAIT, BWAIT, EXEC, DONE; state_o one-hot at all times.
REQ-017 in_ready = 1 in IDLE, OPWAIT, BWAIT; 0 in EXEC, DONE. op_ready = 1 in OPWAIT only.
REQ-018 IDLE: operand accepted -> A <= in_data, go OPWAIT.
REQ-019 OPWAIT: op only -> latch op, go BWAIT; operand only -> A <= in_data (chain restart), stay OPWAIT; both same edge -> latch op, B <= in_data, go EXEC.
REQ-020 BWAIT: operand accepted -> B <= in_data, go EXEC; op_valid ignored.
REQ-021 Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DIV (quotient), 111 PASS B.
REQ-022 Arithmetic unsigned, result truncated to WIDTH bits.
REQ-023 overflow: ADD carry-out; SUB borrow (A < B); MUL nonzero upper WIDTH bits of 2*WIDTH product; 0 for all other ops.
REQ-024 Non-DIV ops and DIV with B = 0 spend exactly 1 cycle in EXEC.
REQ-025 DIV with B != 0: iterative restoring divider, one quotient bit per cycle, exactly WIDTH cycles in EXEC.
REQ-026 DIV with B = 0: result <= all ones, div_zero <= 1, overflow <= 0.
REQ-027 result, overflow, div_zero update only on the EXEC->DONE edge; held until next such edge, clear or reset.
REQ-028 Latency: B accepted at edge k -> result_valid high during cycle after edge k+2 (1-cycle ops) or k+WIDTH+1 (DIV).
REQ-029 DONE lasts 1 cycle, result_valid = 1 only in DONE, then A <= result and go OPWAIT (chaining).
REQ-030 In EXEC, inputs ignored; divider partial state not visible on outputs.
REQ-031 clear high at an edge: state <= IDLE, A, B, result, flags <= 0, result_valid <= 0; clear overrides all same-edge handshakes (nothing accepted).

Reset
REQ-032 reset asserted: immediately (no clock) state IDLE, result 0, result_valid 0, overflow 0, div_zero 0, A/B/op/divider registers 0.
REQ-033 reset mid-EXEC (incl. DIV) abandons the operation; no result_valid after release.
REQ-034 First operand accepted on first rising edge after reset deasserts with in_valid high.

Verification (WIDTH = 8)
REQ-035 A=25, op 000, B=17 -> result 42, overflow 0, result_valid pulse 2 cycles after B edge, state then OPWAIT.
REQ-036 Chain from 42: op 001, B=50 -> result 248, overflow 1; then op 101, B=13 (A=248) -> result 152, overflow 1.
REQ-037 A=100, op 110, B=7 -> result 14, div_zero 0, result_valid exactly 9 cycles after B edge; A=9, op 110, B=0 -> result 255, div_zero 1, 2 cycles.
REQ-038 In OPWAIT with A=5: op 000 and in_data=3 on same edge -> result 8; operand-only 60 then op 011, B=3 -> result 63.
REQ-039 reset asserted during 3rd DIV EXEC cycle -> outputs 0, state_o = 00001 without clock edge, no result_valid; clear in BWAIT with in_valid=1 -> IDLE, operand not captured.
